// File: rtl/riscv_pkg.sv
// Shared definitions for the RISC-V pipeline: result-source and forward-select
// encodings, the registered EX control bundle, and the register-match helper.
package riscv_pkg;

  localparam int XLEN = 32;

  localparam logic [1:0] RESULTSRC_LOAD = 2'b01;

  typedef enum logic [1:0] {
    FWD_RF = 2'b00,
    FWD_W  = 2'b01,
    FWD_M  = 2'b10
  } fwd_sel_e;

  typedef struct packed {
    logic       valid;
    logic       regwrite;
    logic       memwrite;
    logic       branch;
    logic       jump;
    logic [1:0] resultsrc;
  } ex_ctl_t;

  // x0 is hardwired to zero, so a write to it never creates a dependency.
  function automatic logic reg_match(input logic [4:0] rs, input logic [4:0] rd);
    return (rd != 5'd0) && (rs == rd);
  endfunction

endpackage

// File: rtl/forward_unit.sv
// Forward-select for one EX source operand; the MEM-stage producer has priority
// over the WB-stage producer because it holds the younger value.
module forward_unit
  import riscv_pkg::*;
(
  input  logic [4:0] rs_e,
  input  logic [4:0] rd_m,
  input  logic       regwrite_m,
  input  logic [4:0] rd_w,
  input  logic       regwrite_w,
  output fwd_sel_e   sel
);

  always_comb begin
    sel = FWD_RF;
    if (regwrite_m && reg_match(rs_e, rd_m)) begin
      sel = FWD_M;
    end else if (regwrite_w && reg_match(rs_e, rd_w)) begin
      sel = FWD_W;
    end
  end

endmodule

// File: rtl/idex_stage.sv
// ID/EX pipeline register with operand forwarding, load-use stall and flush.
// Build option IDEX_FORWARD_EN: defined = M/W forwarding, only load-use stalls;
// undefined = no forwarding muxes, stall on any EX/MEM register dependency.
module idex_stage
  import riscv_pkg::*;
#(
  parameter int XLEN = riscv_pkg::XLEN
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            valid_d,
  input  logic [XLEN-1:0] rd1_d,
  input  logic [XLEN-1:0] rd2_d,
  input  logic [XLEN-1:0] immext_d,
  input  logic [XLEN-1:0] pc_d,
  input  logic [4:0]      rs1_d,
  input  logic [4:0]      rs2_d,
  input  logic [4:0]      rd_d,
  input  logic [2:0]      alucontrol_d,
  input  logic            alusrc_d,
  input  logic            regwrite_d,
  input  logic            memwrite_d,
  input  logic            branch_d,
  input  logic            jump_d,
  input  logic [1:0]      resultsrc_d,
  input  logic            flush_e,
  input  logic [4:0]      rd_m,
  input  logic            regwrite_m,
  input  logic [XLEN-1:0] aluresult_m,
  input  logic [4:0]      rd_w,
  input  logic            regwrite_w,
  input  logic [XLEN-1:0] result_w,
  output logic            stall_d,
  output logic [XLEN-1:0] srca_e,
  output logic [XLEN-1:0] srcb_e,
  output logic [XLEN-1:0] writedata_e,
  output logic [XLEN-1:0] pc_e,
  output logic [XLEN-1:0] immext_e,
  output logic [4:0]      rd_e,
  output logic [2:0]      alucontrol_e,
  output logic [1:0]      resultsrc_e,
  output logic            valid_e,
  output logic            regwrite_e,
  output logic            memwrite_e,
  output logic            branch_e,
  output logic            jump_e
);

  // valid_d/valid_e qualify the decode and execute slots. There is no
  // back-pressure from EX: stall_d is the only hold signal returned to decode,
  // and a bubble clears every side-effecting control bit of the EX slot.
  ex_ctl_t         ctl_d;
  ex_ctl_t         ctl_q;
  logic            bubble;
  logic            alusrc_e;
  logic [XLEN-1:0] rd1_e;
  logic [XLEN-1:0] rd2_e;
  logic [XLEN-1:0] fwd_a;
  logic [XLEN-1:0] fwd_b;

  assign bubble = flush_e | stall_d | ~valid_d;

  always_comb begin
    ctl_d = '{valid: valid_d, regwrite: regwrite_d, memwrite: memwrite_d,
              branch: branch_d, jump: jump_d, resultsrc: resultsrc_d};
    if (bubble) begin
      ctl_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ctl_q        <= '0;
      alusrc_e     <= 1'b0;
      rd1_e        <= '0;
      rd2_e        <= '0;
      immext_e     <= '0;
      pc_e         <= '0;
      rd_e         <= 5'd0;
      alucontrol_e <= 3'd0;
    end else begin
      ctl_q        <= ctl_d;
      alusrc_e     <= alusrc_d;
      rd1_e        <= rd1_d;
      rd2_e        <= rd2_d;
      immext_e     <= immext_d;
      pc_e         <= pc_d;
      rd_e         <= rd_d;
      alucontrol_e <= alucontrol_d;
    end
  end

`ifdef IDEX_FORWARD_EN
  logic [4:0] rs1_e;
  logic [4:0] rs2_e;
  fwd_sel_e   sel_a;
  fwd_sel_e   sel_b;
  logic       load_use;

  always_ff @(posedge clk) begin
    if (reset) begin
      rs1_e <= 5'd0;
      rs2_e <= 5'd0;
    end else begin
      rs1_e <= rs1_d;
      rs2_e <= rs2_d;
    end
  end

  // Only a load in EX cannot be forwarded in time; everything else is bypassed.
  assign load_use = ctl_q.valid && (ctl_q.resultsrc == RESULTSRC_LOAD) &&
                    (reg_match(rs1_d, rd_e) || reg_match(rs2_d, rd_e));
  assign stall_d  = load_use & ~flush_e;

  forward_unit u_fwd_a (
    .rs_e       (rs1_e),
    .rd_m       (rd_m),
    .regwrite_m (regwrite_m),
    .rd_w       (rd_w),
    .regwrite_w (regwrite_w),
    .sel        (sel_a)
  );

  forward_unit u_fwd_b (
    .rs_e       (rs2_e),
    .rd_m       (rd_m),
    .regwrite_m (regwrite_m),
    .rd_w       (rd_w),
    .regwrite_w (regwrite_w),
    .sel        (sel_b)
  );

  always_comb begin
    fwd_a = rd1_e;
    fwd_b = rd2_e;
    case (sel_a)
      FWD_M:   fwd_a = aluresult_m;
      FWD_W:   fwd_a = result_w;
      default: fwd_a = rd1_e;
    endcase
    case (sel_b)
      FWD_M:   fwd_b = aluresult_m;
      FWD_W:   fwd_b = result_w;
      default: fwd_b = rd2_e;
    endcase
  end
`else
  logic raw_hazard;
  logic unused_fwd;

  // Without bypassing, decode must wait until producers in EX and MEM retire.
  assign raw_hazard = (ctl_q.valid && ctl_q.regwrite &&
                       (reg_match(rs1_d, rd_e) || reg_match(rs2_d, rd_e))) ||
                      (regwrite_m &&
                       (reg_match(rs1_d, rd_m) || reg_match(rs2_d, rd_m)));
  assign stall_d    = raw_hazard & ~flush_e;
  assign fwd_a      = rd1_e;
  assign fwd_b      = rd2_e;
  assign unused_fwd = ^{rd_w, regwrite_w, aluresult_m, result_w};
`endif

  assign srca_e      = fwd_a;
  assign writedata_e = fwd_b;
  assign srcb_e      = alusrc_e ? immext_e : fwd_b;

  assign valid_e     = ctl_q.valid;
  assign regwrite_e  = ctl_q.regwrite;
  assign memwrite_e  = ctl_q.memwrite;
  assign branch_e    = ctl_q.branch;
  assign jump_e      = ctl_q.jump;
  assign resultsrc_e = ctl_q.resultsrc;

endmodule

// File: tb/tb_idex_stage.sv
// Directed bench for idex_stage: the driver pushes the expected EX-slot view per
// cycle into a queue, and a negedge monitor pops and compares it.
module tb_idex_stage;

`ifdef IDEX_FORWARD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        valid_d;
  logic [31:0] rd1_d, rd2_d, immext_d, pc_d;
  logic [4:0]  rs1_d, rs2_d, rd_d;
  logic [2:0]  alucontrol_d;
  logic        alusrc_d, regwrite_d, memwrite_d, branch_d, jump_d;
  logic [1:0]  resultsrc_d;
  logic        flush_e;
  logic [4:0]  rd_m, rd_w;
  logic        regwrite_m, regwrite_w;
  logic [31:0] aluresult_m, result_w;
  logic        stall_d;
  logic [31:0] srca_e, srcb_e, writedata_e, pc_e, immext_e;
  logic [4:0]  rd_e;
  logic [2:0]  alucontrol_e;
  logic [1:0]  resultsrc_e;
  logic        valid_e, regwrite_e, memwrite_e, branch_e, jump_e;

  idex_stage dut (
    .clk(clk), .reset(reset), .valid_d(valid_d),
    .rd1_d(rd1_d), .rd2_d(rd2_d), .immext_d(immext_d), .pc_d(pc_d),
    .rs1_d(rs1_d), .rs2_d(rs2_d), .rd_d(rd_d), .alucontrol_d(alucontrol_d),
    .alusrc_d(alusrc_d), .regwrite_d(regwrite_d), .memwrite_d(memwrite_d),
    .branch_d(branch_d), .jump_d(jump_d), .resultsrc_d(resultsrc_d),
    .flush_e(flush_e), .rd_m(rd_m), .regwrite_m(regwrite_m),
    .aluresult_m(aluresult_m), .rd_w(rd_w), .regwrite_w(regwrite_w),
    .result_w(result_w), .stall_d(stall_d), .srca_e(srca_e), .srcb_e(srcb_e),
    .writedata_e(writedata_e), .pc_e(pc_e), .immext_e(immext_e), .rd_e(rd_e),
    .alucontrol_e(alucontrol_e), .resultsrc_e(resultsrc_e), .valid_e(valid_e),
    .regwrite_e(regwrite_e), .memwrite_e(memwrite_e), .branch_e(branch_e),
    .jump_e(jump_e)
  );

  // ---- clock ----
  always #5 clk = ~clk;

  // ---- scoreboard ----
  typedef struct packed {
    logic [6:0]  ctl;   // {valid,regwrite,memwrite,branch,jump,resultsrc}
    logic [4:0]  rd;
    logic [31:0] imm;
    logic [31:0] pc;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] wd;
    logic        stall;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   n_exp  = 0;
  int   n_mon  = 0;

  task automatic chk(input string nm, input int id, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s vec%0d: got 0x%08h expected 0x%08h", nm, id, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk("ctl",     n_mon, {25'd0, valid_e, regwrite_e, memwrite_e, branch_e,
                             jump_e, resultsrc_e}, {25'd0, e.ctl});
      chk("rd_e",    n_mon, {27'd0, rd_e}, {27'd0, e.rd});
      chk("immext",  n_mon, immext_e, e.imm);
      chk("pc_e",    n_mon, pc_e, e.pc);
      chk("aluctl",  n_mon, {29'd0, alucontrol_e}, {29'd0, e.pc[4:2]});
      chk("srca",    n_mon, srca_e, e.a);
      chk("srcb",    n_mon, srcb_e, e.b);
      chk("wdata",   n_mon, writedata_e, e.wd);
      chk("stall_d", n_mon, {31'd0, stall_d}, {31'd0, e.stall});
      n_mon++;
    end
  end

  // ---- driver tasks ----
  task automatic drv_d(input logic v, input logic [31:0] pc, r1, r2, imm,
                       input logic [4:0] s1, s2, d, input logic asrc, rw, mw,
                       br, jp, input logic [1:0] rsrc);
    valid_d = v; pc_d = pc; rd1_d = r1; rd2_d = r2; immext_d = imm;
    rs1_d = s1; rs2_d = s2; rd_d = d; alusrc_d = asrc; regwrite_d = rw;
    memwrite_d = mw; branch_d = br; jump_d = jp; resultsrc_d = rsrc;
    alucontrol_d = pc[4:2];
  endtask

  task automatic drv_mw(input logic [4:0] dm, input logic rwm, input logic [31:0] am,
                        input logic [4:0] dw, input logic rww, input logic [31:0] rsw);
    rd_m = dm; regwrite_m = rwm; aluresult_m = am;
    rd_w = dw; regwrite_w = rww; result_w = rsw;
  endtask

  task automatic expect_ex(input logic [6:0] ctl, input logic [4:0] rd,
                           input logic [31:0] imm, pc, a, b, wd, input logic st);
    exp_t e;
    e = '{ctl: ctl, rd: rd, imm: imm, pc: pc, a: a, b: b, wd: wd, stall: st};
    exp_q.push_back(e);
    n_exp++;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---- directed stimulus ----
  initial begin
    reset = 1'b1; flush_e = 1'b0;
    drv_mw(5'd0, 1'b0, 32'h0, 5'd0, 1'b0, 32'h0);
    // add x10, x1, x2 (rd1=5, rd2=7)
    drv_d(1, 32'h40, 32'd5, 32'd7, 32'h0, 5'd1, 5'd2, 5'd10, 0, 1, 0, 0, 0, 2'b00);
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;
    expect_ex(7'b0000000, 5'd0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0);
    step();

    // plain ALU op in EX; decode a branch-type op reading x3
    drv_d(1, 32'h44, 32'h99, 32'h55, 32'h0, 5'd3, 5'd0, 5'd4, 0, 1, 0, 1, 0, 2'b00);
    expect_ex(7'b1100000, 5'd10, 32'h0, 32'h40, 32'd5, 32'd7, 32'd7, 1'b0);
    step();

    // MEM and WB both target x3: MEM wins
    drv_mw(5'd3, 1'b1, 32'h11, 5'd3, 1'b1, 32'h22);
    drv_d(1, 32'h48, 32'h66, 32'h0, 32'h24, 5'd6, 5'd0, 5'd7, 0, 0, 1, 0, 0, 2'b00);
    expect_ex(7'b1101000, 5'd4, 32'h0, 32'h44, FWD ? 32'h11 : 32'h99,
              32'h55, 32'h55, 1'b0);
    step();

    // store with rs2=x0 while MEM claims a write to x0
    drv_mw(5'd0, 1'b1, 32'hFF, 5'd0, 1'b0, 32'h0);
    drv_d(1, 32'h4C, 32'h100, 32'h0, 32'h4, 5'd1, 5'd0, 5'd5, 1, 1, 0, 0, 0, 2'b01);
    expect_ex(7'b1010000, 5'd7, 32'h24, 32'h48, 32'h66, 32'h0, 32'h0, 1'b0);
    step();

    // lw x5 in EX, add x8, x5, x2 in decode: load-use
    drv_mw(5'd0, 1'b0, 32'h0, 5'd0, 1'b0, 32'h0);
    drv_d(1, 32'h50, 32'hAA, 32'h3, 32'h0, 5'd5, 5'd2, 5'd8, 0, 1, 0, 0, 0, 2'b00);
    expect_ex(7'b1100001, 5'd5, 32'h4, 32'h4C, 32'h100, 32'h4, 32'h0, 1'b1);
    step();

    // bubble in EX, load now in MEM, add re-presents
    drv_mw(5'd5, 1'b1, 32'h104, 5'd0, 1'b0, 32'h0);
    expect_ex(7'b0000000, 5'd8, 32'h0, 32'h50, FWD ? 32'h104 : 32'hAA,
              32'h3, 32'h3, FWD ? 1'b0 : 1'b1);
    step();

`ifndef IDEX_FORWARD_EN
    // second bubble while the load drains through WB; regfile now holds it
    drv_mw(5'd0, 1'b0, 32'h0, 5'd5, 1'b1, 32'hDEAD);
    drv_d(1, 32'h50, 32'hDEAD, 32'h3, 32'h0, 5'd5, 5'd2, 5'd8, 0, 1, 0, 0, 0, 2'b00);
    expect_ex(7'b0000000, 5'd8, 32'h0, 32'h50, 32'hAA, 32'h3, 32'h3, 1'b0);
    step();
`endif

    // add in EX takes the load data; decode lw x9
    drv_mw(5'd0, 1'b0, 32'h0, 5'd5, 1'b1, 32'hDEAD);
    drv_d(1, 32'h54, 32'h200, 32'h0, 32'h8, 5'd1, 5'd0, 5'd9, 1, 1, 0, 0, 0, 2'b01);
    expect_ex(7'b1100000, 5'd8, 32'h0, 32'h50, 32'hDEAD, 32'h3, 32'h3, 1'b0);
    step();

    // lw x9 in EX with a dependent in decode, but a flush arrives
    drv_mw(5'd8, 1'b1, 32'h77, 5'd0, 1'b0, 32'h0);
    flush_e = 1'b1;
    drv_d(1, 32'h58, 32'h5, 32'h6, 32'h0, 5'd9, 5'd9, 5'd11, 0, 1, 0, 1, 1, 2'b00);
    expect_ex(7'b1100001, 5'd9, 32'h8, 32'h54, 32'h200, 32'h8, 32'h0, 1'b0);
    step();

    // flushed slot: controls cleared, data fields still loaded
    flush_e = 1'b0;
    drv_mw(5'd0, 1'b0, 32'h0, 5'd0, 1'b0, 32'h0);
    drv_d(1, 32'h5C, 32'h300, 32'h0, 32'h10, 5'd0, 5'd0, 5'd12, 1, 1, 0, 0, 0, 2'b01);
    expect_ex(7'b0000000, 5'd11, 32'h0, 32'h58, 32'h5, 32'h6, 32'h6, 1'b0);
    step();

    // lw x12 in EX, dependent in decode stalls; reset arrives mid-stall
    reset = 1'b1;
    drv_d(1, 32'h60, 32'h1, 32'h2, 32'h44, 5'd12, 5'd0, 5'd13, 0, 1, 0, 0, 0, 2'b00);
    expect_ex(7'b1100001, 5'd12, 32'h10, 32'h5C, 32'h300, 32'h10, 32'h0, 1'b1);
    step();

    reset = 1'b0;
    expect_ex(7'b0000000, 5'd0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0);
    step();

    drv_d(0, 32'h0, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0, 2'b00);
    expect_ex(7'b1100000, 5'd13, 32'h44, 32'h60, 32'h1, 32'h2, 32'h2, 1'b0);
    step();

    // drain the scoreboard with a bounded wait
    for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(posedge clk);
    checks++;
    if (exp_q.size() != 0 || n_mon != n_exp) begin
      errors++;
      $display("FAIL drain: monitored %0d expected %0d", n_mon, n_exp);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
